// File: rtl/tick_divider_bank.sv
// tick_divider_bank: bank of independent programmable tick dividers.
// Each channel emits a 1-cycle tick enable every N cycles plus a registered
// square wave (high ceil(N/2), low floor(N/2)). N is rewritten through a
// valid/ready port; a new N on a running channel waits for the period boundary.
module tick_divider_bank #(
   parameter  int unsigned CHANNELS    = 4,
   parameter  int unsigned WIDTH       = 16,
   parameter  int unsigned DEFAULT_DIV = 2080,
   localparam int unsigned CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CW-1:0]       cfg_chan,
   input  logic [WIDTH-1:0]    cfg_div,
   output logic                cfg_err,
   input  logic [CHANNELS-1:0] enable,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] square
);

   localparam int unsigned      NSLOT   = 1 << CW;
   localparam logic [CW:0]      CH_LIM  = (CW + 1)'(CHANNELS);
   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

   if (DEFAULT_DIV == 0 || (64'(DEFAULT_DIV) >> WIDTH) != 64'd0) begin : g_bad_default
      $error("tick_divider_bank: DEFAULT_DIV must be in 1 .. 2**WIDTH-1");
   end

   logic [CHANNELS-1:0] pend_vec;
   logic [NSLOT-1:0]    pend_slot;
   logic                chan_ok;
   logic                accept;
   logic                wr_ok;
   logic                cfg_err_q, cfg_err_d;

   // Config port decode; out-of-range channels read as "ready" so the error is reported
   always_comb begin
      pend_slot                 = '0;
      pend_slot[CHANNELS-1:0]   = pend_vec;
      chan_ok                   = ({1'b0, cfg_chan} < CH_LIM);
      cfg_ready                 = chan_ok ? ~pend_slot[cfg_chan] : 1'b1;
      accept                    = cfg_valid & cfg_ready;
      wr_ok                     = accept & chan_ok & (cfg_div != '0);
      cfg_err_d                 = accept & ~wr_ok;
   end

   // Error pulse for a write that was accepted but rejected
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg_err_d;
      end
   end

   assign cfg_err = cfg_err_q;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] act_q, act_d;
      logic [WIDTH-1:0] pdiv_q, pdiv_d;
      logic             pend_q, pend_d;
      logic             tick_q, tick_d;
      logic             square_q, square_d;
      logic             wr;
      logic             wrap;
      logic [WIDTH-1:0] cnt_nxt;
      logic [WIDTH:0]   half;

      assign wr      = wr_ok && (cfg_chan == CW'(gi));
      assign wrap    = (cnt_q == act_q - WIDTH'(1));
      assign cnt_nxt = wrap ? '0 : cnt_q + WIDTH'(1);
      // One extra bit keeps (N+1)/2 exact when N is all ones
      assign half    = ({1'b0, act_q} + (WIDTH + 1)'(1)) >> 1;

      // Next state: count while enabled, park at phase zero while disabled
      always_comb begin
         cnt_d    = '0;
         act_d    = act_q;
         pdiv_d   = pdiv_q;
         pend_d   = pend_q;
         tick_d   = 1'b0;
         square_d = 1'b0;
         if (enable[gi]) begin
            cnt_d    = cnt_nxt;
            tick_d   = wrap;
            square_d = ({1'b0, cnt_nxt} < half);
            if (wrap && pend_q) begin
               act_d  = pdiv_q;
               pend_d = 1'b0;
            end
            // wr implies pend_q==0 (port not ready otherwise), so no clash with the apply above
            if (wr) begin
               pdiv_d = cfg_div;
               pend_d = 1'b1;
            end
         end else begin
            if (pend_q) begin
               act_d  = pdiv_q;
               pend_d = 1'b0;
            end else if (wr) begin
               act_d = cfg_div;
            end
         end
      end

      // Channel state register
      always_ff @(posedge clock) begin
         if (!reset_n) begin
            cnt_q    <= '0;
            act_q    <= DIV_RST;
            pdiv_q   <= '0;
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
            square_q <= 1'b0;
         end else begin
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            pdiv_q   <= pdiv_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            square_q <= square_d;
         end
      end

      assign tick[gi]     = tick_q;
      assign square[gi]   = square_q;
      assign pend_vec[gi] = pend_q;
   end

endmodule
